// File: rtl/clockdiv_prog.sv
// Runtime-programmable integer clock divider with square/pulse output, tick strobe and glitch-free divisor reload.
// Optional tick_count output enabled by defining CLKDIV_TICKCNT_EN.
module clockdiv_prog #(
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
  output logic [CNT_W-1:0] div_cur,
  output logic             dclk,
`ifdef CLKDIV_TICKCNT_EN
  output logic [15:0]      tick_count,
`endif
  output logic             tick
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } ld_state_e;

  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    if (v < MIN_DIV) begin
      return MIN_DIV;
    end
    return v;
  endfunction

  // ceil(n/2), one bit wider so n = 2^CNT_W-1 does not wrap
  function automatic logic [CNT_W:0] half_up(input logic [CNT_W-1:0] n);
    logic [CNT_W:0] sum;
    sum = {1'b0, n} + (CNT_W+1)'(1);
    return sum >> 1;
  endfunction

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             dclk_q, dclk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic [CNT_W:0]   half;

  always_comb begin
    wrap      = (cnt_q == (div_cur_q - ONE));
    half      = half_up(div_cur_q);
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    pend_d    = pend_q;
    state_d   = state_q;
    dclk_d    = dclk_q;
    tick_d    = 1'b0;

    if (en) begin
      tick_d = wrap;
      dclk_d = mode ? wrap : ({1'b0, cnt_q} < half);
      cnt_d  = wrap ? '0 : (cnt_q + ONE);
      if ((state_q == S_PENDING) && wrap) begin
        div_cur_d = pend_q;
        state_d   = S_IDLE;
      end
    end else if (state_q == S_PENDING) begin
      // Frozen counter has no boundary to wait for: apply now and restart the period.
      div_cur_d = pend_q;
      cnt_d     = '0;
      state_d   = S_IDLE;
    end

    // A load on the apply edge still captures: the old value applies, the new one waits.
    if (div_load) begin
      pend_d  = clamp_div(div_in);
      state_d = S_PENDING;
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_cur_q <= RST_DIV;
      pend_q    <= '0;
      dclk_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      dclk_q    <= dclk_d;
      tick_q    <= tick_d;
    end
  end

`ifdef CLKDIV_TICKCNT_EN
  logic [15:0] tick_count_q, tick_count_d;

  always_comb begin
    tick_count_d = tick_count_q + {15'd0, tick_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count_q <= '0;
    end else begin
      tick_count_q <= tick_count_d;
    end
  end

  assign tick_count = tick_count_q;
`endif

  assign div_pending = (state_q == S_PENDING);
  assign div_cur     = div_cur_q;
  assign dclk        = dclk_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_clockdiv_prog.sv
// Self-checking bench for clockdiv_prog: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_clockdiv_prog;

  localparam int CNT_W = 17;
  localparam int DEF   = 2;
  localparam int MAXN  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, mode, div_load;
  logic [CNT_W-1:0] div_in;
  logic             div_pending, dclk, tick;
  logic [CNT_W-1:0] div_cur;
`ifdef CLKDIV_TICKCNT_EN
  logic [15:0]      tick_count;
`endif

  clockdiv_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .div_in      (div_in),
    .div_load    (div_load),
    .div_pending (div_pending),
    .div_cur     (div_cur),
    .dclk        (dclk),
`ifdef CLKDIV_TICKCNT_EN
    .tick_count  (tick_count),
`endif
    .tick        (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state, plain integers
  int m_cnt, m_div, m_pv, m_pval, m_dclk, m_tick, m_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_cnt = 0; m_div = DEF; m_pv = 0; m_pval = 0;
      m_dclk = 0; m_tick = 0; m_tc = 0;
    end else begin
      if (en) begin
        m_tick = (m_cnt == m_div - 1) ? 1 : 0;
        m_dclk = mode ? m_tick : ((m_cnt < (m_div + 1) / 2) ? 1 : 0);
        if (m_tick == 1) begin
          m_cnt = 0;
          if (m_pv == 1) begin
            m_div = m_pval;
            m_pv  = 0;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_tick = 0;
        if (m_pv == 1) begin
          m_div = m_pval;
          m_pv  = 0;
          m_cnt = 0;
        end
      end
      m_tc = (m_tc + m_tick) & 16'hFFFF;
      if (div_load) begin
        m_pval = (int'(div_in) < 2) ? 2 : int'(div_in);
        m_pv   = 1;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("dclk", {31'd0, dclk}, m_dclk);
    check("tick", {31'd0, tick}, m_tick);
    check("div_pending", {31'd0, div_pending}, m_pv);
    check("div_cur", {15'd0, div_cur}, m_div);
`ifdef CLKDIV_TICKCNT_EN
    check("tick_count", {16'd0, tick_count}, m_tc);
`endif
  endtask

  task automatic load(input int v);
    div_in   = CNT_W'(v);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic wait_apply(input string tag);
    int k = 0;
    while (m_pv == 1 && k < 64) begin
      step();
      k++;
    end
    check(tag, (k < 64) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1; en = 1'b1; mode = 1'b0; div_load = 1'b0; div_in = '0;
    step();
    check("rst_div_cur", {15'd0, div_cur}, DEF);
    check("rst_dclk", {31'd0, dclk}, 0);
    rst = 1'b0;

    // default divide by 2
    repeat (8) step();

    // load 5 mid-period
    step();
    load(5);
    check("pend_after_load", {31'd0, div_pending}, 1);
    wait_apply("apply5_timeout");
    check("div_cur_5", {15'd0, div_cur}, 5);
    repeat (15) step();

    // pulse mode, N = 4
    mode = 1'b1;
    load(4);
    wait_apply("apply4_timeout");
    repeat (12) begin
      step();
      check("pulse_eq_tick", {31'd0, dclk}, {31'd0, tick});
    end
    mode = 1'b0;

    // clamp 0 and 1
    load(0);
    wait_apply("apply0_timeout");
    check("clamp0", {15'd0, div_cur}, 2);
    load(1);
    wait_apply("apply1_timeout");
    check("clamp1", {15'd0, div_cur}, 2);

    // two loads within one period: only the last applies
    load(12);
    wait_apply("apply12_timeout");
    load(7);
    load(9);
    wait_apply("apply9_timeout");
    check("last_load_wins", {15'd0, div_cur}, 9);
    repeat (10) step();

    // en low at cnt = 2 with N = 6
    load(6);
    wait_apply("apply6_timeout");
    k = 0;
    while (m_cnt != 2 && k < 20) begin step(); k++; end
    check("reach_cnt2", (k < 20) ? 32'd1 : 32'd0, 32'd1);
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    k = 0;
    do begin step(); k++; end while (tick !== 1'b1 && k < 20);
    check("resume_tick_latency", k, 4);

    // reset while pending, N = 9
    load(9);
    wait_apply("apply9b_timeout");
    repeat (3) step();
    load(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_pend_div_cur", {15'd0, div_cur}, DEF);
    check("rst_pend_pending", {31'd0, div_pending}, 0);
    check("rst_pend_tick", {31'd0, tick}, 0);
`ifdef CLKDIV_TICKCNT_EN
    check("rst_tick_count", {16'd0, tick_count}, 0);
`endif

    // largest divisor: square output must start high
    load(MAXN);
    wait_apply("applymax_timeout");
    repeat (40) step();
    check("max_dclk_high", {31'd0, dclk}, 1);
    load(3);
    en = 1'b0;
    step();
    check("en_low_apply", {15'd0, div_cur}, 3);
    en = 1'b1;
    repeat (10) step();

    // randomized traffic
    repeat (800) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      div_load = ($urandom_range(0, 14) == 0);
      div_in   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 1))
                                               : CNT_W'($urandom_range(2, 12));
      step();
    end
    rst = 1'b0; div_load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
